// File: rtl/nn_inference_sequencer.sv
// Frame-level sequencer for the jet-tagging inference core.
// Accepts one feature frame, launches the core, waits (with a watchdog)
// for the result, then holds the class scores for a valid/ready consumer.
// Only one frame is ever in flight.
module nn_inference_sequencer #(
    parameter int WIDTH          = 16,
    parameter int NFRAC          = 10,
    parameter int INPUT_SIZE     = 16,
    parameter int OUTPUT_SIZE    = 5,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [INPUT_SIZE-1:0][WIDTH-1:0]        s_data,
    output logic                                    core_start,
    output logic [INPUT_SIZE-1:0][WIDTH-1:0]        core_in_data,
    input  logic                                    core_done,
    input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]       core_out_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]       m_data,
    output logic                                    busy,
    output logic                                    timeout_err,
    input  logic                                    clear_err,
    output logic [CNT_WIDTH-1:0]                    frame_count,
    output logic [CNT_WIDTH-1:0]                    last_latency
);

    // Wait counter must hold TIMEOUT_CYCLES itself.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [INPUT_SIZE-1:0][WIDTH-1:0]     in_q, in_d;
    logic [OUTPUT_SIZE-1:0][WIDTH-1:0]    out_q, out_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]                 lat_q, lat_d;
    logic [CNT_WIDTH-1:0]                 fcnt_q, fcnt_d;
    logic                                 err_q, err_d;
    logic [CW-1:0]                        wait_cnt;
    logic                                 err_set;

    // cnt_q counts completed WAIT cycles; wait_cnt is the 1-based index of
    // the current WAIT cycle, so a core answering N cycles after the start
    // pulse reports latency N.
    assign wait_cnt = cnt_q + CW'(1);

    // Handshake/status outputs decode straight from the state. s_ready is
    // also gated by reset so it reads 0 while reset is held.
    assign s_ready      = (state_q == IDLE) && reset;
    assign core_start   = (state_q == LAUNCH);
    assign m_valid      = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign core_in_data = in_q;
    assign m_data       = out_q;
    assign timeout_err  = err_q;
    assign frame_count  = fcnt_q;
    assign last_latency = lat_q;

    // State and datapath registers; reset discards any in-flight frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            in_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and register updates for the frame sequence.
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        fcnt_d  = fcnt_q;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    in_d    = s_data;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = wait_cnt;
                // A result arriving on the last allowed cycle still counts.
                if (core_done) begin
                    out_d   = core_out_data;
                    lat_d   = CNT_WIDTH'(wait_cnt);
                    state_d = HOLD;
                end else if (wait_cnt == TMO) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    fcnt_d  = fcnt_q + CNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Sticky watchdog flag: a new abort beats a simultaneous clear.
        if (err_set)        err_d = 1'b1;
        else if (clear_err) err_d = 1'b0;
        else                err_d = err_q;
    end

endmodule
